data_mem_responder: RTL

- Word-organised data memory that acts as the responder on the core's req/gnt/rvalid data interface. It is the target end of the load/store port driven by the memory stage.
- Accepts one request per grant and applies byte enables on writes. Returns read data, or a write acknowledge, with a programmable number of wait cycles.
- Used as the simulation/FPGA data RAM behind the core, and as the reference responder in core benches.

---
 rtl/data_mem_if.sv | 25 ++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Core data port: one-outstanding req/gnt handshake with an rvalid response
// channel. The master is the core memory stage; the slave is the data RAM.
interface data_mem_if #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
);
    logic                      data_req_i;
    logic                      data_gnt_o;
    logic [MEM_ADDR_WIDTH-1:0] data_addr_i;
    logic                      data_wr_i;
    logic [3:0]                data_be_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic [DATA_WIDTH-1:0]     data_rdata_o;
    logic                      data_rvalid_o;

    modport master (
        output data_req_i, data_addr_i, data_wr_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rdata_o, data_rvalid_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_wr_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rdata_o, data_rvalid_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering the core req/gnt/rvalid port with a
// fixed number of wait cycles between grant and response.
module data_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 10,
    parameter int WAIT_CYCLES    = 1
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic                    wr_r;
    logic [3:0]              be_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    rvalid_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    gnt_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic                    enter_resp_s;
    logic [DEPTH_LOG2-1:0]   resp_idx_s;
    logic                    resp_wr_s;
    logic [3:0]              resp_be_s;
    logic [DATA_WIDTH-1:0]   resp_wdata_s;
    logic                    addr_unused_s;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

    // Low two bits and bits above the array span do not select a word.
    assign idx_s         = bus.data_addr_i[DEPTH_LOG2+1:2];
    assign addr_unused_s = ^{bus.data_addr_i[MEM_ADDR_WIDTH-1:DEPTH_LOG2+2], bus.data_addr_i[1:0]};

    assign bus.data_gnt_o    = gnt_s;
    assign bus.data_rvalid_o = rvalid_r;
    assign bus.data_rdata_o  = rdata_r;

    // Accept a request whenever no transaction is waiting out its latency.
    always_comb begin
        if (rst) begin
            gnt_s = 1'b0;
        end else if (state_r == ST_IDLE || state_r == ST_RESP) begin
            gnt_s = bus.data_req_i;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Select the transaction whose response starts at the coming edge.
    always_comb begin
        enter_resp_s = 1'b0;
        resp_idx_s   = idx_r;
        resp_wr_s    = wr_r;
        resp_be_s    = be_r;
        resp_wdata_s = wdata_r;
        if (NO_WAIT && gnt_s) begin
            enter_resp_s = 1'b1;
            resp_idx_s   = idx_s;
            resp_wr_s    = bus.data_wr_i;
            resp_be_s    = bus.data_be_i;
            resp_wdata_s = bus.data_wdata_i;
        end else if (!rst && state_r == ST_WAIT && cnt_r == 4'd0) begin
            enter_resp_s = 1'b1;
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    // Writes land on the edge entering RESP, so a reset during WAIT drops them.
    always_ff @(posedge clk) begin
        if (enter_resp_s && resp_wr_s) begin
            mem_r[resp_idx_s] <= merge_lanes(mem_r[resp_idx_s], resp_wdata_s, resp_be_s);
        end
    end

    // Handshake FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            idx_r    <= {DEPTH_LOG2{1'b0}};
            wr_r     <= 1'b0;
            be_r     <= 4'd0;
            wdata_r  <= {DATA_WIDTH{1'b0}};
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (gnt_s) begin
                        idx_r   <= idx_s;
                        wr_r    <= bus.data_wr_i;
                        be_r    <= bus.data_be_i;
                        wdata_r <= bus.data_wdata_i;
                        if (NO_WAIT) begin
                            state_r <= ST_RESP;
                        end else begin
                            cnt_r   <= WAIT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            rvalid_r <= enter_resp_s;
            // Read data is sampled after any earlier write has committed.
            if (enter_resp_s) begin
                rdata_r <= resp_wr_s ? {DATA_WIDTH{1'b0}} : mem_r[resp_idx_s];
            end
        end
    end
endmodule
